stream_upsize_packer: RTL and testbench

//   Packs RATIO consecutive narrow valid/ready beats into one wide beat, LSB lane first.

---
 rtl/stream_upsize_packer.sv | 85 ++++++++
 tb/tb_stream_upsize_packer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize_packer.sv
// Packs ratio narrow valid/ready beats into one wide word, lane 0 first.
// A beat with up_last closes a partial word early; down_keep marks the filled lanes.
module stream_upsize_packer #(
    parameter int in_width = 8,
    parameter int ratio = 4,
    localparam int out_width = in_width * ratio,
    localparam int cnt_w = (ratio > 1) ? $clog2(ratio) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [in_width-1:0]  up_data,
    input  logic                 up_last,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [out_width-1:0] down_data,
    output logic [ratio-1:0]     down_keep,
    output logic                 down_last
);

    // Handshake: a transfer happens on a posedge where valid & ready are both 1.
    // down_* stay stable while down_valid & ~down_ready; up_ready depends only on
    // down_valid and down_ready, so a full output slot accepts a closing beat
    // in the same cycle it is popped.
    localparam logic [cnt_w-1:0] last_lane = cnt_w'(ratio - 1);

    logic [out_width-1:0] acc;
    logic [cnt_w-1:0]     cnt;
    logic [out_width-1:0] merged;
    logic [ratio-1:0]     keep_next;
    logic                 closing;
    logic                 up_fire;
    logic                 down_fire;

    assign up_ready  = ~down_valid | down_ready;
    assign up_fire   = up_valid & up_ready;
    assign down_fire = down_valid & down_ready;
    assign closing   = (cnt == last_lane) | up_last;

    // acc with lane cnt replaced by the incoming beat and higher lanes cleared
    always_comb begin
        merged    = '0;
        keep_next = '0;
        for (int k = 0; k < ratio; k++) begin
            if (k < int'(cnt)) begin
                merged[k*in_width +: in_width] = acc[k*in_width +: in_width];
            end else if (k == int'(cnt)) begin
                merged[k*in_width +: in_width] = up_data;
            end
            if (k <= int'(cnt)) begin
                keep_next[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            cnt        <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_keep  <= '0;
            down_last  <= 1'b0;
        end else begin
            if (up_fire && closing) begin
                down_data  <= merged;
                down_keep  <= keep_next;
                down_last  <= up_last;
                down_valid <= 1'b1;
                cnt        <= '0;
                acc        <= '0;
            end else begin
                if (up_fire) begin
                    acc <= merged;
                    cnt <= cnt + 1'b1;
                end
                if (down_fire) begin
                    down_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_upsize_packer.sv
// Directed and random stimulus for stream_upsize_packer (in_width=8, ratio=4)
// with a queue of expected wide words checked on every downstream transfer.
module tb_stream_upsize_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_valid;
    logic        up_ready;
    logic [7:0]  up_data;
    logic        up_last;
    logic        down_valid;
    logic        down_ready;
    logic [31:0] down_data;
    logic [3:0]  down_keep;
    logic        down_last;

    int vectors = 0;
    int miscompares = 0;
    bit rand_mode = 1'b0;

    // {last, keep, data}
    logic [36:0] exp_q[$];
    logic [31:0] m_acc = '0;
    int          m_cnt = 0;

    stream_upsize_packer #(.in_width(8), .ratio(4)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_last(up_last),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
        .down_keep(down_keep), .down_last(down_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic l);
        logic [3:0] kk;
        m_acc[m_cnt*8 +: 8] = d;
        if (l || m_cnt == 3) begin
            kk = 4'((1 << (m_cnt + 1)) - 1);
            exp_q.push_back({l, kk, m_acc});
            m_acc = '0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    // Drive a beat and hold it until accepted; returns how many cycles it stalled.
    task automatic send_beat(input logic [7:0] d, input logic l, output int waited);
        waited = 0;
        up_valid = 1'b1;
        up_data  = d;
        up_last  = l;
        forever begin
            @(negedge clk);
            if (up_ready) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 64'(waited), 64'd0);
                up_valid = 1'b0;
                return;
            end
        end
        model_accept(d, l);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every downstream transfer pops one expected word.
    always @(negedge clk) begin
        if (rst && down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'(down_data), 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("sb_data", 64'(down_data), 64'(e[31:0]));
                check("sb_keep", 64'(down_keep), 64'(e[35:32]));
                check("sb_last", 64'(down_last), 64'(e[36]));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            down_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int w;
        rst = 1'b0;
        up_valid = 1'b0;
        up_data = '0;
        up_last = 1'b0;
        down_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_down_valid", 64'(down_valid), 64'd0);
        check("rst_down_data", 64'(down_data), 64'd0);
        check("rst_down_keep", 64'(down_keep), 64'd0);
        check("rst_down_last", 64'(down_last), 64'd0);
        check("rst_up_ready", 64'(up_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full word
        send_beat(8'h11, 1'b0, w);
        send_beat(8'h22, 1'b0, w);
        send_beat(8'h33, 1'b0, w);
        send_beat(8'h44, 1'b0, w);
        check("full_valid", 64'(down_valid), 64'd1);
        check("full_data", 64'(down_data), 64'h44332211);

        // Partial word, then the next word must start in lane 0
        send_beat(8'hAA, 1'b0, w);
        send_beat(8'hBB, 1'b1, w);
        check("partial_data", 64'(down_data), 64'h0000BBAA);
        check("partial_keep", 64'(down_keep), 64'h3);
        drain();

        // Backpressure: word held, then pop and reload in the same cycle
        down_ready = 1'b0;
        send_beat(8'hC1, 1'b1, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(down_valid), 64'd1);
            check("bp_data", 64'(down_data), 64'h000000C1);
            check("bp_keep", 64'(down_keep), 64'h1);
            check("bp_last", 64'(down_last), 64'd1);
            check("bp_up_ready", 64'(up_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        up_valid = 1'b1;
        up_data = 8'hD2;
        up_last = 1'b1;
        down_ready = 1'b1;
        model_accept(8'hD2, 1'b1);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        check("swap_valid", 64'(down_valid), 64'd1);
        check("swap_data", 64'(down_data), 64'h000000D2);
        drain();

        // Streaming: no stall on any beat
        for (int i = 0; i < 16; i++) begin
            send_beat(8'(i), 1'b0, w);
            check("stream_no_stall", 64'(w), 64'd0);
        end
        drain();

        // Reset mid-word with a previous word still on the output registers
        send_beat(8'hF0, 1'b1, w);
        send_beat(8'h55, 1'b0, w);
        send_beat(8'h66, 1'b0, w);
        #2;
        rst = 1'b0;
        #1;
        check("arst_down_valid", 64'(down_valid), 64'd0);
        check("arst_down_data", 64'(down_data), 64'd0);
        check("arst_down_keep", 64'(down_keep), 64'd0);
        check("arst_down_last", 64'(down_last), 64'd0);
        check("arst_up_ready", 64'(up_ready), 64'd1);
        exp_q.delete();
        m_acc = '0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_beat(8'h01, 1'b0, w);
        send_beat(8'h02, 1'b0, w);
        send_beat(8'h03, 1'b0, w);
        send_beat(8'h04, 1'b0, w);
        check("post_rst_data", 64'(down_data), 64'h04030201);
        check("post_rst_keep", 64'(down_keep), 64'hF);
        drain();

        // Random bubbles on both sides
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
            send_beat(8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) == 0), w);
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        down_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
